// File: rtl/ndn_fib_top_if.sv
// ndn_fib_top_if: name bus into the FIB lookup pipeline and its 1-bit result taps.
//   name_in                        name, component k = [32k+31:32k]
//   dummy_output_0                 result hit flag
//   dummy_output_1..4              result next-hop bits [0]..[3]
//   debug_address_pipeline_reg_0   XOR-reduce of the stage-0 address register
// master = name source / result sink, slave = the lookup pipeline.
interface ndn_fib_top_if #(
  parameter int unsigned NAME_W = 256
);
  logic [NAME_W-1:0] name_in;
  logic              dummy_output_0;
  logic              dummy_output_1;
  logic              dummy_output_2;
  logic              dummy_output_3;
  logic              dummy_output_4;
  logic              debug_address_pipeline_reg_0;

  modport master (
    output name_in,
    input  dummy_output_0, dummy_output_1, dummy_output_2, dummy_output_3,
           dummy_output_4, debug_address_pipeline_reg_0
  );

  modport slave (
    input  name_in,
    output dummy_output_0, dummy_output_1, dummy_output_2, dummy_output_3,
           dummy_output_4, debug_address_pipeline_reg_0
  );
endinterface

// File: rtl/ndn_fib_top.sv
// ndn_fib_top: single-issue pipelined NDN FIB longest-prefix lookup.
// Accepts one name per cycle and walks it through TREE_HEIGHT stages. Each stage
// holds a node ROM of 2**POINTER_SIZE BST nodes over 32-bit component hashes; a
// key match descends to the child pointer for the next component.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; flushes every in-flight name
//   bus    ndn_fib_top_if.slave (name_in in, registered result bits out)
// ROM_IMAGE holds TREE_HEIGHT*2**POINTER_SIZE 64-bit node words; stage s node a is
// word s*2**POINTER_SIZE+a. The default image is all zero (every lookup misses).
// Node word: [31:0] key, [37:32] left, [43:38] right, [49:44] child,
// [53:50] nexthop, [54] is_end, [55] valid. Pointer 0 is null.
// Latency: name sampled at edge N reaches the outputs after edge N+TREE_HEIGHT.
module ndn_fib_top #(
  parameter int unsigned TREE_HEIGHT       = 6,
  parameter int unsigned WORD_SIZE         = 32,
  parameter int unsigned MAX_NAME_LENGTH   = 8,
  parameter int unsigned POINTER_SIZE      = 6,
  parameter int unsigned STRIDE_INDEX_SIZE = 3,
  parameter logic [TREE_HEIGHT*(2**POINTER_SIZE)*64-1:0] ROM_IMAGE = '0
) (
  input logic         clk,
  input logic         reset,
  ndn_fib_top_if.slave bus
);

  localparam int unsigned NAME_W    = MAX_NAME_LENGTH * WORD_SIZE;
  localparam int unsigned DEPTH     = 2 ** POINTER_SIZE;
  localparam int unsigned NODE_W    = 64;
  localparam int unsigned NH_W      = 4;
  localparam int unsigned ROM_W     = TREE_HEIGHT * DEPTH * NODE_W;
  localparam int unsigned ROM_AW    = $clog2(ROM_W);
  localparam int unsigned OFF_LEFT  = WORD_SIZE;
  localparam int unsigned OFF_RIGHT = OFF_LEFT + POINTER_SIZE;
  localparam int unsigned OFF_CHILD = OFF_RIGHT + POINTER_SIZE;
  localparam int unsigned OFF_NH    = OFF_CHILD + POINTER_SIZE;
  localparam int unsigned OFF_END   = OFF_NH + NH_W;
  localparam int unsigned OFF_VALID = OFF_END + 1;

  // Index 0 is the input register; index s+1 is the output of stage s.
  logic [NAME_W-1:0]            name_q   [0:TREE_HEIGHT];
  logic [NAME_W-1:0]            name_d   [0:TREE_HEIGHT];
  logic [POINTER_SIZE-1:0]      addr_q   [0:TREE_HEIGHT];
  logic [POINTER_SIZE-1:0]      addr_d   [0:TREE_HEIGHT];
  logic [STRIDE_INDEX_SIZE-1:0] stride_q [0:TREE_HEIGHT];
  logic [STRIDE_INDEX_SIZE-1:0] stride_d [0:TREE_HEIGHT];
  logic                         alive_q  [0:TREE_HEIGHT];
  logic                         alive_d  [0:TREE_HEIGHT];
  logic                         hit_q    [0:TREE_HEIGHT];
  logic                         hit_d    [0:TREE_HEIGHT];
  logic [NH_W-1:0]              nh_q     [0:TREE_HEIGHT];
  logic [NH_W-1:0]              nh_d     [0:TREE_HEIGHT];

  // Per-stage decoded node fields and current name component.
  logic [ROM_AW-1:0]       base_c  [TREE_HEIGHT];
  logic [WORD_SIZE-1:0]    key_c   [TREE_HEIGHT];
  logic [WORD_SIZE-1:0]    comp_c  [TREE_HEIGHT];
  logic [POINTER_SIZE-1:0] left_c  [TREE_HEIGHT];
  logic [POINTER_SIZE-1:0] right_c [TREE_HEIGHT];
  logic [POINTER_SIZE-1:0] child_c [TREE_HEIGHT];
  logic [NH_W-1:0]         nhrom_c [TREE_HEIGHT];
  logic                    end_c   [TREE_HEIGHT];
  logic                    valid_c [TREE_HEIGHT];

  // Next-state for the input register and every lookup stage.
  always_comb begin
    name_d[0]   = bus.name_in;
    addr_d[0]   = '0;
    stride_d[0] = '0;
    alive_d[0]  = 1'b1;
    hit_d[0]    = 1'b0;
    nh_d[0]     = '0;
    for (int s = 0; s < TREE_HEIGHT; s++) begin
      base_c[s]  = ROM_AW'(s * DEPTH * NODE_W) + ROM_AW'(32'(addr_q[s]) * NODE_W);
      key_c[s]   = ROM_IMAGE[base_c[s] +: WORD_SIZE];
      left_c[s]  = ROM_IMAGE[base_c[s] + ROM_AW'(OFF_LEFT) +: POINTER_SIZE];
      right_c[s] = ROM_IMAGE[base_c[s] + ROM_AW'(OFF_RIGHT) +: POINTER_SIZE];
      child_c[s] = ROM_IMAGE[base_c[s] + ROM_AW'(OFF_CHILD) +: POINTER_SIZE];
      nhrom_c[s] = ROM_IMAGE[base_c[s] + ROM_AW'(OFF_NH) +: NH_W];
      end_c[s]   = ROM_IMAGE[base_c[s] + ROM_AW'(OFF_END)];
      valid_c[s] = ROM_IMAGE[base_c[s] + ROM_AW'(OFF_VALID)];
      comp_c[s]  = name_q[s][32'(stride_q[s]) * WORD_SIZE +: WORD_SIZE];

      name_d[s+1]   = name_q[s];
      addr_d[s+1]   = addr_q[s];
      stride_d[s+1] = stride_q[s];
      alive_d[s+1]  = alive_q[s];
      hit_d[s+1]    = hit_q[s];
      nh_d[s+1]     = nh_q[s];

      if (alive_q[s]) begin
        // A zero component marks the end of the name.
        if (!valid_c[s] || comp_c[s] == '0) begin
          alive_d[s+1] = 1'b0;
        end else if (comp_c[s] == key_c[s]) begin
          // Later matches overwrite nh, so the longest prefix wins.
          if (end_c[s]) begin
            hit_d[s+1] = 1'b1;
            nh_d[s+1]  = nhrom_c[s];
          end
          stride_d[s+1] = stride_q[s] + STRIDE_INDEX_SIZE'(1);
          addr_d[s+1]   = child_c[s];
          if (child_c[s] == '0 ||
              stride_q[s] == STRIDE_INDEX_SIZE'(MAX_NAME_LENGTH - 1)) begin
            alive_d[s+1] = 1'b0;
          end
        end else if (comp_c[s] < key_c[s]) begin
          addr_d[s+1] = left_c[s];
          if (left_c[s] == '0) alive_d[s+1] = 1'b0;
        end else begin
          addr_d[s+1] = right_c[s];
          if (right_c[s] == '0) alive_d[s+1] = 1'b0;
        end
      end
    end
  end

  // Pipeline registers with synchronous flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i <= TREE_HEIGHT; i++) begin
      if (reset) begin
        name_q[i]   <= '0;
        addr_q[i]   <= '0;
        stride_q[i] <= '0;
        alive_q[i]  <= 1'b0;
        hit_q[i]    <= 1'b0;
        nh_q[i]     <= '0;
      end else begin
        name_q[i]   <= name_d[i];
        addr_q[i]   <= addr_d[i];
        stride_q[i] <= stride_d[i];
        alive_q[i]  <= alive_d[i];
        hit_q[i]    <= hit_d[i];
        nh_q[i]     <= nh_d[i];
      end
    end
  end

  assign bus.dummy_output_0               = hit_q[TREE_HEIGHT];
  assign bus.dummy_output_1               = nh_q[TREE_HEIGHT][0];
  assign bus.dummy_output_2               = nh_q[TREE_HEIGHT][1];
  assign bus.dummy_output_3               = nh_q[TREE_HEIGHT][2];
  assign bus.dummy_output_4               = nh_q[TREE_HEIGHT][3];
  assign bus.debug_address_pipeline_reg_0 = ^addr_q[1];

endmodule

// File: tb/tb_ndn_fib_top.sv
// Bench for ndn_fib_top: two instances with different node ROM images share one
// name stream; each vector carries the expected {hit, nh[3:0]} for both.
module tb_ndn_fib_top;

  localparam int unsigned TH     = 6;
  localparam int unsigned NAME_W = 256;
  localparam int unsigned IMG_W  = TH * 64 * 64;

  function automatic logic [63:0] mk_node(input logic [31:0] key,
                                          input logic [5:0] left, input logic [5:0] right,
                                          input logic [5:0] child, input logic [3:0] nh,
                                          input logic is_end, input logic valid);
    return {8'h00, valid, is_end, nh, child, right, left, key};
  endfunction

  function automatic logic [IMG_W-1:0] place(input int unsigned s, input int unsigned a,
                                             input logic [63:0] w);
    logic [IMG_W-1:0] v;
    v = '0;
    v[(s * 64 + a) * 64 +: 64] = w;
    return v;
  endfunction

  function automatic logic [NAME_W-1:0] nm(input logic [31:0] c0, input logic [31:0] c1,
                                           input logic [31:0] c2);
    logic [NAME_W-1:0] v;
    v = '0;
    v[31:0]  = c0;
    v[63:32] = c1;
    v[95:64] = c2;
    return v;
  endfunction

  // A: root 0xA (end, nh 5) -> child 3 in stage 1: 0xB (end, nh 9).
  localparam logic [IMG_W-1:0] IMG_A =
      place(0, 0, mk_node(32'h0000000A, 6'd0, 6'd0, 6'd3, 4'h5, 1'b1, 1'b1)) |
      place(1, 3, mk_node(32'h0000000B, 6'd0, 6'd0, 6'd0, 4'h9, 1'b1, 1'b1));

  // B: root 0x10 (not end, left null, right 2); stage1[2] 0x20 (nh 3, left 4, right 5);
  // stage2[4] 0x18 (nh C); stage2[5] 0x80000000 (nh E).
  localparam logic [IMG_W-1:0] IMG_B =
      place(0, 0, mk_node(32'h00000010, 6'd0, 6'd2, 6'd0, 4'h0, 1'b0, 1'b1)) |
      place(1, 2, mk_node(32'h00000020, 6'd4, 6'd5, 6'd0, 4'h3, 1'b1, 1'b1)) |
      place(2, 4, mk_node(32'h00000018, 6'd0, 6'd0, 6'd0, 4'hC, 1'b1, 1'b1)) |
      place(2, 5, mk_node(32'h80000000, 6'd0, 6'd0, 6'd0, 4'hE, 1'b1, 1'b1));

  logic clk;
  logic reset;

  ndn_fib_top_if #(.NAME_W(NAME_W)) if_a ();
  ndn_fib_top_if #(.NAME_W(NAME_W)) if_b ();

  ndn_fib_top #(.TREE_HEIGHT(TH), .ROM_IMAGE(IMG_A)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  ndn_fib_top #(.TREE_HEIGHT(TH), .ROM_IMAGE(IMG_B)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result as {hit, nh[3:0]}.
  logic [4:0] res_a, res_b;
  assign res_a = {if_a.dummy_output_0, if_a.dummy_output_4, if_a.dummy_output_3,
                  if_a.dummy_output_2, if_a.dummy_output_1};
  assign res_b = {if_b.dummy_output_0, if_b.dummy_output_4, if_b.dummy_output_3,
                  if_b.dummy_output_2, if_b.dummy_output_1};

  int total;
  int bad;

  typedef struct {
    logic [NAME_W-1:0] name;
    logic [4:0]        exp_a;
    logic [4:0]        exp_b;
  } vec_t;

  localparam int unsigned NV = 13;
  vec_t vecs [NV];

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [NAME_W-1:0] n);
    if_a.name_in = n;
    if_b.name_in = n;
  endtask

  initial begin
    logic [4:0] ea, eb;
    total = 0;
    bad   = 0;

    vecs[0]  = '{nm(32'h0, 32'h0, 32'h0),        5'h00, 5'h00};
    vecs[1]  = '{nm(32'hA, 32'h0, 32'h0),        5'h15, 5'h00};
    vecs[2]  = '{nm(32'hA, 32'hB, 32'h0),        5'h19, 5'h00};
    vecs[3]  = '{nm(32'hA, 32'hC, 32'h0),        5'h15, 5'h00};
    vecs[4]  = '{nm(32'h08, 32'h0, 32'h0),       5'h00, 5'h00};
    vecs[5]  = '{nm(32'h20, 32'h0, 32'h0),       5'h00, 5'h13};
    vecs[6]  = '{nm(32'h18, 32'h0, 32'h0),       5'h00, 5'h1C};
    vecs[7]  = '{nm(32'h80000000, 32'h0, 32'h0), 5'h00, 5'h1E};
    vecs[8]  = '{nm(32'h10, 32'h0, 32'h0),       5'h00, 5'h00};
    vecs[9]  = '{nm(32'h30, 32'h0, 32'h0),       5'h00, 5'h00};
    vecs[10] = '{nm(32'hB, 32'h0, 32'h0),        5'h00, 5'h00};
    vecs[11] = '{nm(32'h0, 32'hA, 32'h0),        5'h00, 5'h00};
    vecs[12] = '{nm(32'hA, 32'hB, 32'h5),        5'h19, 5'h00};

    // Reset, then idle all-zero names.
    reset = 1'b1;
    drive('0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("reset_a[%0d]", i), res_a, 5'h00);
      check($sformatf("reset_b[%0d]", i), res_b, 5'h00);
    end
    reset = 1'b0;
    for (int i = 0; i < int'(TH) + 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle_a[%0d]", i), res_a, 5'h00);
      check($sformatf("idle_b[%0d]", i), res_b, 5'h00);
    end

    // Directed vectors, one in flight at a time.
    for (int v = 0; v < int'(NV); v++) begin
      drive(vecs[v].name);
      repeat (TH + 1) @(posedge clk);
      #1;
      check($sformatf("vec_a[%0d]", v), res_a, vecs[v].exp_a);
      check($sformatf("vec_b[%0d]", v), res_b, vecs[v].exp_b);
    end

    // Stage-0 address register: 0x20 goes right to node 2, 0x08 hits a null left.
    drive(nm(32'h20, 32'h0, 32'h0));
    repeat (2) @(posedge clk);
    #1;
    check("dbg_right", {4'h0, if_b.debug_address_pipeline_reg_0}, 5'h01);
    drive(nm(32'h08, 32'h0, 32'h0));
    repeat (2) @(posedge clk);
    #1;
    check("dbg_null", {4'h0, if_b.debug_address_pipeline_reg_0}, 5'h00);

    // Back-to-back names alternating 0xA / 0x20.
    for (int c = 0; c < 8 + int'(TH); c++) begin
      if (c < 8) drive(((c % 2) == 0) ? nm(32'hA, 32'h0, 32'h0) : nm(32'h20, 32'h0, 32'h0));
      else       drive('0);
      @(posedge clk); #1;
      if (c >= int'(TH)) begin
        ea = (((c - int'(TH)) % 2) == 0) ? 5'h15 : 5'h00;
        eb = (((c - int'(TH)) % 2) == 0) ? 5'h00 : 5'h13;
        check($sformatf("b2b_a[%0d]", c - int'(TH)), res_a, ea);
        check($sformatf("b2b_b[%0d]", c - int'(TH)), res_b, eb);
      end
    end

    // Reset with three 0xA/0xB names in flight; 0xA sampled from the first edge after deassert.
    for (int c = 0; c < 12; c++) begin
      drive((c < 3) ? nm(32'hA, 32'hB, 32'h0) : nm(32'hA, 32'h0, 32'h0));
      reset = (c == 3 || c == 4);
      @(posedge clk); #1;
      if (c >= 3) begin
        ea = (c >= 11) ? 5'h15 : 5'h00;
        check($sformatf("flush_a[%0d]", c), res_a, ea);
        check($sformatf("flush_b[%0d]", c), res_b, 5'h00);
      end
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
